instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Instruction fetch stage between the program-counter/instruction-ROM side and `instruction_decoder`. It generates sequential fetch addresses into a synchronous-read instruction memory and buffers returned 27-bit instructions with their PCs in a small FIFO. It presents them to the decoder with a valid/ready handshake and flushes on a jump redirect.

## Interface
- `INSTR_W`, 27: instruction width.
- `ADDR_W`, 15: fetch address width, matching `pc_load_data`.
- `DEPTH`, 4: FIFO entries; a power of two, minimum 2.
- `RESET_ADDR`, 0: first fetch address after reset.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_req` out 1: fetch request this cycle.
- `imem_addr` out `ADDR_W`: fetch address; valid when `imem_req` is high.
- `imem_rdata` in `INSTR_W`: instruction for the request issued in the previous cycle (fixed latency 1).
- `redirect` in 1: jump taken; flush the queue and restart fetch.
- `redirect_addr` in `ADDR_W`: new fetch address, sampled when `redirect` is high.
- `instr_valid` out 1: FIFO head valid.
- `instr` out `INSTR_W`: FIFO head instruction.
- `instr_pc` out `ADDR_W`: address of the FIFO head instruction.
- `instr_ready` in 1: decoder accepts the head this cycle.
- `occupancy` out clog2(`DEPTH`)+1: number of FIFO entries.

## Operation
- FSM states: FETCH, FULL, REDIR. Reset state is FETCH.
  - FETCH drives `imem_req`=1 when credit is available. Credit means `occupancy` + in-flight + (push this cycle) − (pop this cycle) < `DEPTH`.
  - With no credit: FETCH→FULL and `imem_req`=0. FULL→FETCH on the first cycle credit exists; the request is issued in that same cycle.
  - `redirect` from any state: go to REDIR. In REDIR `imem_req`=0 for exactly one cycle, then REDIR→FETCH. `redirect` asserted again while in REDIR stays in REDIR and reloads the address.
- `fetch_pc`: advances +1 on each issued request and wraps from 2^`ADDR_W`−1 to 0. On `redirect` it loads `redirect_addr`.
- In-flight tracking: a 1-bit in-flight flag plus a stored request PC.
  - The response is pushed the cycle after the request, as {`imem_rdata`, request PC}.
  - A `squash` bit is set on `redirect`; a squashed response is discarded and never pushed.
- FIFO:
  - Push and pop in the same cycle are both allowed; `occupancy` is unchanged.
  - A pop happens when `instr_valid` and `instr_ready` are both high.
  - Pop from empty is ignored. Push when full cannot happen because of credit; the bench asserts this.
- Redirect priority: a handshake in the same cycle as `redirect` completes (the decoder owns that instruction). Then every entry is flushed and `occupancy`=0 next cycle.
- Reset values: `imem_req`=0, `imem_addr`=`RESET_ADDR`, `instr_valid`=0, `instr`=0, `instr_pc`=0, `occupancy`=0, in-flight=0, squash=0.
- Reset mid-operation discards all entries and in-flight data. The first request after release goes to `RESET_ADDR`.

## Timing
- Cycle 0 is the first cycle with `rst` low: `imem_req`=1, `imem_addr`=`RESET_ADDR`.
- Cycle 1: data arrives and is pushed at the end of the cycle.
- Cycle 2: `instr_valid`=1. Request-to-valid latency is 2 cycles.
- Steady state with `instr_ready` held high: one instruction per cycle.
- Redirect asserted in cycle N:
  - cycle N+1: REDIR, no request, `instr_valid`=0;
  - cycle N+2: request to `redirect_addr`;
  - cycle N+4: `instr_valid`=1.
  - Redirect penalty is 3 bubble cycles at the decoder.
- Outputs are registered or FIFO-read (no combinational path from `instr_ready` to `instr`). `imem_req` depends combinationally on `instr_ready` through credit.

## Configuration
- `FETCH_PERF_EN` defined adds two output ports, each 16 bits, saturating at 16'hFFFF and cleared by `rst`:
  - `stall_cnt`: increments each cycle `instr_valid`=0 outside reset.
  - `flush_cnt`: increments once per `redirect` cycle.
- `FETCH_PERF_EN` undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release with ROM word = address, `instr_ready`=1 → requests at 0,1,2,…; `instr_valid` from cycle 2; `instr_pc`=`instr`=0,1,2,… with no gaps.
- `instr_ready`=0 for 10 cycles → exactly `DEPTH` (4) requests; FSM reaches FULL; `occupancy`=4; `imem_req`=0. Then `instr_ready`=1 → request 4 issued in the same cycle; head PC sequence 0..5 unbroken.
- `redirect`=1 with `redirect_addr`=15'h0100 while one request is in flight and FIFO holds 3 → that response is discarded; `occupancy`=0 next cycle; next `instr_pc`=0x0100 appears 4 cycles after redirect.
- `redirect` while `instr_valid`&`instr_ready` → handshaken instruction counted consumed; no stale PC is ever presented afterwards.
- Fetch from `redirect_addr`=15'h7FFE → PCs 7FFE, 7FFF, 0000, 0001.
- With `FETCH_PERF_EN`: 3 redirects → `flush_cnt`=3; `stall_cnt` equals the observed invalid cycles. `rst` pulse mid-stream → counters 0, `occupancy` 0, next request to `RESET_ADDR`.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: sequential fetch into a 1-cycle-latency instruction memory, small FIFO to the decoder.
// Optional FETCH_PERF_EN adds saturating stall/flush counters.
`timescale 1ns/1ps
module instr_fetch_queue #(
  parameter int unsigned       INSTR_W    = 27,
  parameter int unsigned       ADDR_W     = 15,
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INSTR_W-1:0]       imem_rdata,
  input  logic                     redirect,
  input  logic [ADDR_W-1:0]        redirect_addr,
  output logic                     instr_valid,
  output logic [INSTR_W-1:0]       instr,
  output logic [ADDR_W-1:0]        instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              flush_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {FETCH, FULL, REDIR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   fetch_pc;
  logic                inflight, squash;
  logic [ADDR_W-1:0]   req_pc;
  logic [INSTR_W-1:0]  mem_data [DEPTH];
  logic [ADDR_W-1:0]   mem_pc   [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count, level;
  logic                push, pop, credit;

  assign push        = inflight & ~squash;
  assign pop         = instr_valid & instr_ready;
  // Entries held after this cycle, before any new request is counted
  assign level       = count + CNT_W'(push) - CNT_W'(pop);
  assign credit      = level < CNT_W'(DEPTH);

  assign instr_valid = (count != '0);
  assign instr       = mem_data[rd_ptr];
  assign instr_pc    = mem_pc[rd_ptr];
  assign occupancy   = count;
  assign imem_addr   = fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next state and request; redirect overrides every state
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      FETCH: begin
        if (credit) imem_req  = 1'b1;
        else        state_nxt = FULL;
      end
      FULL: begin
        if (credit) begin
          imem_req  = 1'b1;
          state_nxt = FETCH;
        end
      end
      REDIR:   state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
    if (redirect) state_nxt = REDIR;
    if (rst)      imem_req  = 1'b0;
  end

  // Fetch address and the single outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_ADDR;
      inflight <= 1'b0;
      squash   <= 1'b0;
      req_pc   <= '0;
    end else begin
      inflight <= imem_req;
      req_pc   <= fetch_pc;
      squash   <= redirect;
      if (redirect)      fetch_pc <= redirect_addr;
      else if (imem_req) fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  // FIFO; a redirect completes any same-cycle pop, then empties everything
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[PTR_W'(i)] <= '0;
        mem_pc[PTR_W'(i)]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= imem_rdata;
        mem_pc[wr_ptr]   <= req_pc;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= level;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!instr_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (redirect && flush_cnt != 16'hFFFF)     flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed self-checking bench for instr_fetch_queue; ROM word equals its address.
`timescale 1ns/1ps
module tb_instr_fetch_queue;
  localparam int unsigned INSTR_W = 27;
  localparam int unsigned ADDR_W  = 15;
  localparam int unsigned DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               redirect = 1'b0;
  logic [ADDR_W-1:0]  redirect_addr = '0;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready = 1'b1;
  logic [2:0]         occupancy;
`ifdef FETCH_PERF_EN
  logic [15:0]        stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_queue #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_ADDR('0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_addr(redirect_addr), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .occupancy(occupancy)
`ifdef FETCH_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read ROM, word = address
  always @(posedge clk) imem_rdata <= INSTR_W'(imem_addr);

  // Credit must keep the FIFO from ever overfilling
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      n_checks++;
      if (occupancy > 3'(DEPTH)) begin
        n_fail++;
        $display("FAIL occupancy_bound: got %0d limit %0d", occupancy, DEPTH);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_addr = '0;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    repeat (3) cyc();
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== 15'h0000) begin n_fail++; $display("FAIL rst_addr: got %h want 0000", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_checks++; if (instr !== 27'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_checks++; if (instr_pc !== 15'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
    n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_stream();
    instr_ready = 1'b1;
    do_reset();
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 15'h0) begin n_fail++; $display("FAIL stream_c0: req %b addr %h want 1 0000", imem_req, imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c0_valid: got %b want 0", instr_valid); end
    cyc(); #1;
    n_checks++; if (instr_valid !== 1'b0 || imem_addr !== 15'h1) begin n_fail++; $display("FAIL stream_c1: valid %b addr %h want 0 0001", instr_valid, imem_addr); end
    for (int k = 2; k < 10; k++) begin
      cyc(); #1;
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== ADDR_W'(k-2) || instr !== INSTR_W'(k-2) || imem_addr !== ADDR_W'(k)) begin
        n_fail++;
        $display("FAIL stream_c%0d: valid %b pc %h instr %h addr %h want 1 %h %h %h", k, instr_valid, instr_pc, instr, imem_addr, k-2, k-2, k);
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    int exp_pc = 0;
    instr_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      #1; if (imem_req) nreq++;
      cyc();
    end
    #1;
    n_checks++; if (nreq !== 4) begin n_fail++; $display("FAIL bp_req_count: got %0d want 4", nreq); end
    n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occ: got %0d want 4", occupancy); end
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== 15'h4) begin n_fail++; $display("FAIL bp_stalled: req %b addr %h want 0 0004", imem_req, imem_addr); end
    instr_ready = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 15'h4) begin n_fail++; $display("FAIL bp_resume: req %b addr %h want 1 0004", imem_req, imem_addr); end
    for (int c = 0; c < 20 && exp_pc < 6; c++) begin
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (instr_pc !== ADDR_W'(exp_pc) || instr !== INSTR_W'(exp_pc)) begin
          n_fail++; $display("FAIL bp_seq: pc %h instr %h want %h", instr_pc, instr, exp_pc);
        end
        exp_pc++;
      end
      cyc(); #1;
    end
    n_checks++; if (exp_pc !== 6) begin n_fail++; $display("FAIL bp_pops: got %0d want 6", exp_pc); end
  endtask

  task automatic test_redirect_flush();
    instr_ready = 1'b0;
    do_reset();
    repeat (4) cyc();
    #1;
    n_checks++; if (occupancy !== 3'd3 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rf_pre: occ %0d req %b want 3 0", occupancy, imem_req); end
    redirect = 1'b1; redirect_addr = 15'h0100;
    cyc(); redirect = 1'b0; instr_ready = 1'b1; #1;
    n_checks++; if (occupancy !== 3'd0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL rf_n1: occ %0d valid %b req %b want 0 0 0", occupancy, instr_valid, imem_req); end
    cyc(); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 15'h0100 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rf_n2: req %b addr %h valid %b want 1 0100 0", imem_req, imem_addr, instr_valid); end
    cyc(); #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rf_n3: valid %b want 0", instr_valid); end
    cyc(); #1;
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 15'h0100 || instr !== 27'h100) begin n_fail++; $display("FAIL rf_n4: valid %b pc %h instr %h want 1 0100 100", instr_valid, instr_pc, instr); end
    cyc(); #1;
    n_checks++; if (instr_pc !== 15'h0101) begin n_fail++; $display("FAIL rf_n5: pc %h want 0101", instr_pc); end
  endtask

  task automatic test_redirect_handshake();
    instr_ready = 1'b1;
    do_reset();
    repeat (5) cyc();
    #1;
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 15'h3) begin n_fail++; $display("FAIL rh_pre: valid %b pc %h want 1 0003", instr_valid, instr_pc); end
    redirect = 1'b1; redirect_addr = 15'h0200;
    cyc(); redirect = 1'b0; #1;
    for (int i = 1; i <= 3; i++) begin
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rh_bubble%0d: valid %b pc %h want 0", i, instr_valid, instr_pc); end
      cyc(); #1;
    end
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 15'h0200) begin n_fail++; $display("FAIL rh_n4: valid %b pc %h want 1 0200", instr_valid, instr_pc); end
    cyc(); #1;
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 15'h0201) begin n_fail++; $display("FAIL rh_n5: valid %b pc %h want 1 0201", instr_valid, instr_pc); end
  endtask

  task automatic test_back_to_back_redirect();
    instr_ready = 1'b1;
    do_reset();
    repeat (4) cyc();
    redirect = 1'b1; redirect_addr = 15'h0010;
    cyc(); redirect_addr = 15'h0020; #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_n1: req %b want 0", imem_req); end
    cyc(); redirect = 1'b0; #1;
    n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_n2: req %b valid %b want 0 0", imem_req, instr_valid); end
    cyc(); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 15'h0020) begin n_fail++; $display("FAIL b2b_n3: req %b addr %h want 1 0020", imem_req, imem_addr); end
    cyc(); #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_n4: valid %b want 0", instr_valid); end
    cyc(); #1;
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 15'h0020) begin n_fail++; $display("FAIL b2b_n5: valid %b pc %h want 1 0020", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a [4];
    exp_a = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    instr_ready = 1'b1;
    do_reset();
    repeat (2) cyc();
    redirect = 1'b1; redirect_addr = 15'h7FFE;
    cyc(); redirect = 1'b0;
    cyc();
    for (int i = 0; i < 6; i++) begin
      #1;
      if (i < 4) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_a[i]) begin n_fail++; $display("FAIL wrap_addr%0d: req %b addr %h want 1 %h", i, imem_req, imem_addr, exp_a[i]); end
      end
      if (i >= 2) begin
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== exp_a[i-2] || instr !== INSTR_W'(exp_a[i-2])) begin
          n_fail++; $display("FAIL wrap_pc%0d: valid %b pc %h instr %h want 1 %h", i, instr_valid, instr_pc, instr, exp_a[i-2]);
        end
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b1;
    do_reset();
    repeat (5) cyc();
    rst = 1'b1; #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_in_rst: got %b want 0", imem_req); end
    cyc(); rst = 1'b0; #1;
    n_checks++; if (occupancy !== 3'd0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL rm_flushed: occ %0d valid %b want 0 0", occupancy, instr_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 15'h0) begin n_fail++; $display("FAIL rm_restart: req %b addr %h want 1 0000", imem_req, imem_addr); end
    cyc(); cyc(); #1;
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 15'h0) begin n_fail++; $display("FAIL rm_first: valid %b pc %h want 1 0000", instr_valid, instr_pc); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    int inval = 0;
    instr_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      redirect = (c == 4 || c == 10 || c == 16);
      redirect_addr = ADDR_W'(c * 16);
      #1; if (!instr_valid) inval++;
      cyc();
    end
    redirect = 1'b0; #1;
    n_checks++; if (flush_cnt !== 16'd3) begin n_fail++; $display("FAIL perf_flush: got %0d want 3", flush_cnt); end
    n_checks++; if (stall_cnt !== 16'd11) begin n_fail++; $display("FAIL perf_stall: got %0d want 11", stall_cnt); end
    n_checks++; if (32'(stall_cnt) !== inval) begin n_fail++; $display("FAIL perf_stall_obs: got %0d observed %0d", stall_cnt, inval); end
    rst = 1'b1;
    cyc(); #1;
    n_checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL perf_rst: stall %0d flush %0d occ %0d want 0 0 0", stall_cnt, flush_cnt, occupancy); end
    rst = 1'b0; #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 15'h0) begin n_fail++; $display("FAIL perf_restart: req %b addr %h want 1 0000", imem_req, imem_addr); end
    cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_handshake();
    test_back_to_back_redirect();
    test_wrap();
    test_reset_mid();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
